alu_seq_unit: RTL and testbench
===============================

# alu_seq_unit

Arithmetic/logic stage directly downstream of the register file: consumes the two 16-bit read ports (OutA, OutB) and produces a registered 16-bit result plus a 4-bit flag register (Z, C, N, O). Single-cycle operations complete on the issuing edge. Multiply runs as an iterative 16-cycle shift-add sequence with a Start/Busy/Done handshake, so the control unit can stall on it.

## Interface
- WIDTH, 16, datapath width; fixed at 16 for this release.
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-high reset.
- A  in  16  operand A (register file OutA).
- B  in  16  operand B (register file OutB).
- FunSel  in  4  operation select, sampled with Start.
- WF  in  1  write-flags enable, sampled with Start.
- Start  in  1  issue request, honoured only in IDLE.
- ALUOut  out  16  registered result.
- FlagsOut  out  4  {Z,C,N,O} flag register.
- Busy  out  1  high while a multiply is in progress.
- Done  out  1  one-cycle pulse after a result is written.

## Operation
- FunSel decode:
  - 0000 A; 0001 B; 0010 ~A; 0011 ~B.
  - 0100 A+B; 0101 A+B+C (C = current flag); 0110 A-B (A+~B+1).
  - 0111 A&B; 1000 A|B; 1001 A^B; 1010 ~(A&B).
  - 1011 LSL A; 1100 LSR A; 1101 ASR A; 1110 CSL A (rotate left through C).
  - 1111 MUL (low 16 bits of unsigned A*B).
- States:
  - IDLE: Start=1 with FunSel≠1111 writes ALUOut (and flags if WF) on that edge and stays in IDLE. Start=1 with FunSel=1111 latches A, B, WF and moves to MUL.
  - MUL: 16 iterations, one per edge, on a 5-bit counter. Each iteration adds mcand to the 32-bit acc if mplier[0]=1, then mcand<<=1 and mplier>>=1. The 16th iteration writes ALUOut=acc[15:0], updates flags if the latched WF=1, and returns to IDLE.
- Flags are updated only when WF=1; otherwise all four hold.
  - Z = (result==0); N = result[15] for every op.
  - C: add/sub take the 17th-bit carry out (sub: 1 = no borrow). Shifts and CSL take the bit shifted out. MUL sets C = (acc[31:16]≠0). Pass/logic ops hold C.
  - O: signed overflow for add/ADC/sub. All other ops hold O.
- Start while Busy=1 is ignored (no queueing). A and B are not required to be stable during MUL.

## Timing
- Reset (async): ALUOut=0, FlagsOut=0, Busy=0, Done=0, state=IDLE, counter/acc cleared. A reset mid-MUL aborts the operation with no result or flag write.
- Single-cycle op: issue at edge n → ALUOut/FlagsOut valid and Done=1 after edge n; Done drops after edge n+1 unless another op issues. Busy stays 0.
- Back-to-back single ops (Start held high): one result per cycle, Done stays high.
- MUL: issue at edge n → Busy=1 after edge n. Iterations run on edges n+1..n+16. Result, flags, Done=1 and Busy=0 take effect after edge n+16. Latency is 16 cycles, and a new Start is accepted at edge n+17.
- ALUOut and FlagsOut hold their values between operations.

## Test plan
- ADD overflow: A=0x7FFF, B=0x0001, FunSel=0100, WF=1, Start pulse → next cycle ALUOut=0x8000, FlagsOut={Z0,C0,N1,O1}, Done=1 for 1 cycle.
- SUB equal, then WF=0:
  - A=0x0005, B=0x0005, FunSel=0110, WF=1 → ALUOut=0x0000, Z=1, C=1, N=0, O=0.
  - Then FunSel=0111 (AND), A=0xFFFF, B=0x00F0, WF=0 → ALUOut=0x00F0, flags unchanged.
- Shifts: C preset to 1, A=0x8001.
  - CSL → ALUOut=0x0003, C=1.
  - ASR on 0x8001 → ALUOut=0xC000, C=1, N=1.
- MUL: A=0x0123, B=0x0045, FunSel=1111, WF=1, Start at edge 0.
  - Busy=1 for exactly 16 cycles.
  - After edge 16: ALUOut=0x4E6F, Z=0, C=0, Done=1.
  - A Start pulse at edge 5 has no effect.
- MUL high-half and abort:
  - 0x0100×0x0100 → ALUOut=0x0000, Z=1, C=1.
  - Repeat with Reset asserted at cycle 8 → all outputs 0 immediately, no Done pulse. A new ADD issued after release completes normally.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// Operand/result bundle between the register-file read ports, control unit and alu_seq_unit.
// The master drives operands and the issue request; the slave returns result, flags and handshake.
interface alu_seq_unit_if #(
   parameter int WIDTH = 16
);
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [3:0]       FunSel;
   logic             WF;
   logic             Start;
   logic [WIDTH-1:0] ALUOut;
   logic [3:0]       FlagsOut;
   logic             Busy;
   logic             Done;

   modport master (
      output A, B, FunSel, WF, Start,
      input  ALUOut, FlagsOut, Busy, Done
   );

   modport slave (
      input  A, B, FunSel, WF, Start,
      output ALUOut, FlagsOut, Busy, Done
   );
endinterface

// File: rtl/alu_seq_unit.sv
// Register-file-fed ALU: single-cycle ops complete on the issuing edge, MUL runs as a
// 16-step shift-add sequence behind a Busy/Done handshake. Flags are {Z,C,N,O}.
module alu_seq_unit #(
   parameter int WIDTH = 16
) (
   input  logic          clk,
   input  logic          rst,
   alu_seq_unit_if.slave bus
);
   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_t;

   localparam logic [3:0] OP_PASS_A = 4'b0000;
   localparam logic [3:0] OP_PASS_B = 4'b0001;
   localparam logic [3:0] OP_NOT_A  = 4'b0010;
   localparam logic [3:0] OP_NOT_B  = 4'b0011;
   localparam logic [3:0] OP_ADD    = 4'b0100;
   localparam logic [3:0] OP_ADC    = 4'b0101;
   localparam logic [3:0] OP_SUB    = 4'b0110;
   localparam logic [3:0] OP_AND    = 4'b0111;
   localparam logic [3:0] OP_OR     = 4'b1000;
   localparam logic [3:0] OP_XOR    = 4'b1001;
   localparam logic [3:0] OP_NAND   = 4'b1010;
   localparam logic [3:0] OP_LSL    = 4'b1011;
   localparam logic [3:0] OP_LSR    = 4'b1100;
   localparam logic [3:0] OP_ASR    = 4'b1101;
   localparam logic [3:0] OP_CSL    = 4'b1110;
   localparam logic [3:0] OP_MUL    = 4'b1111;

   localparam int FZ = 3;
   localparam int FC = 2;
   localparam int FN = 1;
   localparam int FO = 0;

   localparam logic [4:0] LAST_ITER = 5'(WIDTH - 1);

   state_t               state_q, state_d;
   logic [4:0]           cnt_q, cnt_d;
   logic [2*WIDTH-1:0]   acc_q, acc_d;
   logic [2*WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]     mplier_q, mplier_d;
   logic                 wf_q, wf_d;
   logic [WIDTH-1:0]     alu_out_q, alu_out_d;
   logic [3:0]           flags_q, flags_d;
   logic                 done_q, done_d;

   logic [WIDTH-1:0]     op_res;
   logic                 op_c;
   logic                 op_o;
   logic [WIDTH:0]       sum;
   logic [2*WIDTH-1:0]   acc_step;

   // Single-cycle datapath; C and O default to their held values for ops that don't define them.
   always_comb begin
      op_res = '0;
      op_c   = flags_q[FC];
      op_o   = flags_q[FO];
      sum    = '0;
      unique case (bus.FunSel)
         OP_PASS_A: op_res = bus.A;
         OP_PASS_B: op_res = bus.B;
         OP_NOT_A:  op_res = ~bus.A;
         OP_NOT_B:  op_res = ~bus.B;
         OP_ADD: begin
            sum    = {1'b0, bus.A} + {1'b0, bus.B};
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_o   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_ADC: begin
            sum    = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, flags_q[FC]};
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_o   = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_SUB: begin
            // Two's-complement subtract: carry out of A + ~B + 1 means "no borrow".
            sum    = {1'b0, bus.A} + {1'b0, ~bus.B} + {{WIDTH{1'b0}}, 1'b1};
            op_res = sum[WIDTH-1:0];
            op_c   = sum[WIDTH];
            op_o   = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (sum[WIDTH-1] != bus.A[WIDTH-1]);
         end
         OP_AND:  op_res = bus.A & bus.B;
         OP_OR:   op_res = bus.A | bus.B;
         OP_XOR:  op_res = bus.A ^ bus.B;
         OP_NAND: op_res = ~(bus.A & bus.B);
         OP_LSL: begin
            op_res = {bus.A[WIDTH-2:0], 1'b0};
            op_c   = bus.A[WIDTH-1];
         end
         OP_LSR: begin
            op_res = {1'b0, bus.A[WIDTH-1:1]};
            op_c   = bus.A[0];
         end
         OP_ASR: begin
            op_res = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]};
            op_c   = bus.A[0];
         end
         OP_CSL: begin
            op_res = {bus.A[WIDTH-2:0], flags_q[FC]};
            op_c   = bus.A[WIDTH-1];
         end
         OP_MUL:  op_res = '0;
         default: op_res = '0;
      endcase
   end

   assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      wf_d      = wf_q;
      alu_out_d = alu_out_q;
      flags_d   = flags_q;
      done_d    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               if (bus.FunSel == OP_MUL) begin
                  // Operands are captured here so the register file may change during the sequence.
                  mcand_d  = {{WIDTH{1'b0}}, bus.A};
                  mplier_d = bus.B;
                  acc_d    = '0;
                  cnt_d    = '0;
                  wf_d     = bus.WF;
                  state_d  = S_MUL;
               end else begin
                  alu_out_d = op_res;
                  done_d    = 1'b1;
                  if (bus.WF) begin
                     flags_d[FZ] = (op_res == '0);
                     flags_d[FC] = op_c;
                     flags_d[FN] = op_res[WIDTH-1];
                     flags_d[FO] = op_o;
                  end
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_step;
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + 5'd1;
            if (cnt_q == LAST_ITER) begin
               alu_out_d = acc_step[WIDTH-1:0];
               done_d    = 1'b1;
               state_d   = S_IDLE;
               if (wf_q) begin
                  flags_d[FZ] = (acc_step[WIDTH-1:0] == '0);
                  flags_d[FC] = (acc_step[2*WIDTH-1:WIDTH] != '0);
                  flags_d[FN] = acc_step[WIDTH-1];
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         wf_q      <= 1'b0;
         alu_out_q <= '0;
         flags_q   <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         wf_q      <= wf_d;
         alu_out_q <= alu_out_d;
         flags_q   <= flags_d;
         done_q    <= done_d;
      end
   end

   assign bus.ALUOut   = alu_out_q;
   assign bus.FlagsOut = flags_q;
   assign bus.Busy     = (state_q == S_MUL);
   assign bus.Done     = done_q;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Self-checking bench for alu_seq_unit: directed scenarios plus randomized traffic, all
// compared every cycle against an arithmetic reference model of the ALU.
module tb_alu_seq_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;

   alu_seq_unit_if #(.WIDTH(16)) bus ();

   alu_seq_unit #(.WIDTH(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   logic [15:0] m_out   = '0;
   logic [3:0]  m_flags = '0;
   logic        m_busy  = 1'b0;
   logic        m_done  = 1'b0;
   int          m_left  = 0;
   logic [31:0] m_prod  = '0;
   logic        m_wf    = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Returns {result, Z, C, N, O} using integer arithmetic on the operand values.
   function automatic logic [19:0] ref_op(input logic [3:0] f, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] fl);
      int ua, ub, sa, sb, cin, t, s;
      logic [15:0] r;
      logic c, o;
      ua  = int'(a);
      ub  = int'(b);
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      cin = fl[2] ? 1 : 0;
      c   = fl[2];
      o   = fl[0];
      r   = '0;
      t   = 0;
      s   = 0;
      case (f)
         4'h0: r = a;
         4'h1: r = b;
         4'h2: r = ~a;
         4'h3: r = ~b;
         4'h4: begin t = ua + ub; s = sa + sb; r = t[15:0]; c = (t > 65535); o = (s > 32767) || (s < -32768); end
         4'h5: begin t = ua + ub + cin; s = sa + sb + cin; r = t[15:0]; c = (t > 65535); o = (s > 32767) || (s < -32768); end
         4'h6: begin t = ua - ub; s = sa - sb; r = t[15:0]; c = (ua >= ub); o = (s > 32767) || (s < -32768); end
         4'h7: r = a & b;
         4'h8: r = a | b;
         4'h9: r = a ^ b;
         4'hA: r = ~(a & b);
         4'hB: begin r = a << 1; c = a[15]; end
         4'hC: begin r = a >> 1; c = a[0]; end
         4'hD: begin r = (a >> 1) | (a & 16'h8000); c = a[0]; end
         4'hE: begin r = (a << 1) | {15'b0, fl[2]}; c = a[15]; end
         default: r = '0;
      endcase
      return {r, (r == 16'h0000), c, r[15], o};
   endfunction

   task automatic model_step();
      logic [19:0] r;
      if (rst) begin
         m_out = '0; m_flags = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
      end else begin
         m_done = 1'b0;
         if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
               m_busy = 1'b0;
               m_done = 1'b1;
               m_out  = m_prod[15:0];
               if (m_wf)
                  m_flags = {m_out == 16'h0000, m_prod[31:16] != 16'h0000, m_out[15], m_flags[0]};
            end
         end else if (bus.Start) begin
            $display("txn t=%0t fun=%h a=%h b=%h wf=%b", $time, bus.FunSel, bus.A, bus.B, bus.WF);
            if (bus.FunSel == 4'hF) begin
               m_prod = 32'(bus.A) * 32'(bus.B);
               m_wf   = bus.WF;
               m_left = 16;
               m_busy = 1'b1;
            end else begin
               r     = ref_op(bus.FunSel, bus.A, bus.B, m_flags);
               m_out = r[19:4];
               if (bus.WF) m_flags = r[3:0];
               m_done = 1'b1;
            end
         end
      end
   endtask

   initial forever begin
      @(posedge clk or posedge rst);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      check("cyc_aluout", 32'(bus.ALUOut), 32'(m_out));
      check("cyc_flags", 32'(bus.FlagsOut), 32'(m_flags));
      check("cyc_busy", 32'(bus.Busy), 32'(m_busy));
      check("cyc_done", 32'(bus.Done), 32'(m_done));
   end

   task automatic issue(input logic [3:0] f, input logic [15:0] a, input logic [15:0] b, input logic w);
      bus.FunSel = f; bus.A = a; bus.B = b; bus.WF = w; bus.Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 7))
         0: return 16'h0000;
         1: return 16'hFFFF;
         2: return 16'h8000;
         3: return 16'h7FFF;
         default: return 16'($urandom());
      endcase
   endfunction

   initial begin
      int busy_cnt;
      int done_edge;
      int done_cnt;
      bus.A = '0; bus.B = '0; bus.FunSel = '0; bus.WF = 1'b0; bus.Start = 1'b0;

      check("model_add_ovf", 32'(ref_op(4'h4, 16'h7FFF, 16'h0001, 4'h0)), 32'({16'h8000, 4'b0011}));
      check("model_sub_eq", 32'(ref_op(4'h6, 16'h0005, 16'h0005, 4'h0)), 32'({16'h0000, 4'b1100}));
      check("model_csl", 32'(ref_op(4'hE, 16'h8001, 16'h0000, 4'b0100)), 32'({16'h0003, 4'b0100}));
      check("model_asr", 32'(ref_op(4'hD, 16'h8001, 16'h0000, 4'b0100)), 32'({16'hC000, 4'b0110}));

      #1;
      check("rst_aluout", 32'(bus.ALUOut), 32'h0);
      check("rst_flags", 32'(bus.FlagsOut), 32'h0);
      check("rst_busy", 32'(bus.Busy), 32'h0);
      check("rst_done", 32'(bus.Done), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      issue(4'h4, 16'h7FFF, 16'h0001, 1'b1);
      check("add_ovf_out", 32'(bus.ALUOut), 32'h8000);
      check("add_ovf_flags", 32'(bus.FlagsOut), 32'b0011);
      check("add_ovf_done", 32'(bus.Done), 32'h1);
      @(posedge clk);
      #1;
      check("add_ovf_done_drop", 32'(bus.Done), 32'h0);

      issue(4'h6, 16'h0005, 16'h0005, 1'b1);
      check("sub_eq_out", 32'(bus.ALUOut), 32'h0000);
      check("sub_eq_flags", 32'(bus.FlagsOut), 32'b1100);
      issue(4'h7, 16'hFFFF, 16'h00F0, 1'b0);
      check("and_nowf_out", 32'(bus.ALUOut), 32'h00F0);
      check("and_nowf_flags", 32'(bus.FlagsOut), 32'b1100);
      check("and_nowf_done", 32'(bus.Done), 32'h1);

      issue(4'h4, 16'hFFFF, 16'h0001, 1'b1);
      check("cpreset_flags", 32'(bus.FlagsOut), 32'b1100);
      issue(4'hE, 16'h8001, 16'h0000, 1'b1);
      check("csl_out", 32'(bus.ALUOut), 32'h0003);
      check("csl_flags", 32'(bus.FlagsOut), 32'b0100);
      issue(4'hD, 16'h8001, 16'h0000, 1'b1);
      check("asr_out", 32'(bus.ALUOut), 32'hC000);
      check("asr_flags", 32'(bus.FlagsOut), 32'b0110);

      // MUL with an ignored Start pulse at edge 5.
      issue(4'hF, 16'h0123, 16'h0045, 1'b1);
      busy_cnt  = bus.Busy ? 1 : 0;
      done_edge = -1;
      for (int e = 1; e <= 40 && done_edge < 0; e++) begin
         if (e == 5) begin
            bus.FunSel = 4'h4; bus.A = 16'h0001; bus.B = 16'h0001; bus.WF = 1'b1; bus.Start = 1'b1;
         end
         @(posedge clk);
         #1;
         bus.Start = 1'b0;
         if (bus.Busy) busy_cnt++;
         if (bus.Done) done_edge = e;
      end
      check("mul_busy_cycles", 32'(busy_cnt), 32'd16);
      check("mul_done_edge", 32'(done_edge), 32'd16);
      check("mul_out", 32'(bus.ALUOut), 32'h4E6F);
      check("mul_flags", 32'(bus.FlagsOut), 32'b0000);
      @(posedge clk);
      #1;
      check("mul_done_drop", 32'(bus.Done), 32'h0);

      issue(4'hF, 16'h0100, 16'h0100, 1'b1);
      for (int e = 0; e < 40 && !bus.Done; e++) begin
         @(posedge clk);
         #1;
      end
      check("mulhi_out", 32'(bus.ALUOut), 32'h0000);
      check("mulhi_flags", 32'(bus.FlagsOut), 32'b1100);

      issue(4'hF, 16'h0100, 16'h0100, 1'b1);
      repeat (8) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("abort_aluout", 32'(bus.ALUOut), 32'h0);
      check("abort_flags", 32'(bus.FlagsOut), 32'h0);
      check("abort_busy", 32'(bus.Busy), 32'h0);
      check("abort_done", 32'(bus.Done), 32'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      done_cnt = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clk);
         #1;
         if (bus.Done) done_cnt++;
      end
      check("abort_no_done", 32'(done_cnt), 32'h0);
      issue(4'h4, 16'h0002, 16'h0003, 1'b1);
      check("post_abort_out", 32'(bus.ALUOut), 32'h0005);
      check("post_abort_flags", 32'(bus.FlagsOut), 32'b0000);
      check("post_abort_done", 32'(bus.Done), 32'h1);

      for (int i = 0; i < 1500; i++) begin
         bus.Start  = ($urandom_range(0, 99) < 55);
         bus.FunSel = 4'($urandom_range(0, 15));
         bus.A      = pick();
         bus.B      = pick();
         bus.WF     = ($urandom_range(0, 3) != 0);
         @(posedge clk);
         #1;
      end
      bus.Start = 1'b0;
      repeat (20) @(posedge clk);
      #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
